// File: rtl/ace_snoop_responder.sv
// ACE snoop slave: AC request -> cache lookup -> CR response -> optional CD line stream,
// plus a one-shot cache state-update pulse. Optional macro ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN.
package ace_snoop_responder_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    localparam logic [3:0] SNP_READ_ONCE       = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED     = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN      = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD        = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE     = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED    = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID   = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID    = 4'b1101;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        snoop;
        logic [2:0]        prot;
    } ac_chan_t;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_chan_t cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

endpackage

module ace_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned CdBeats   = 8,
    parameter type ac_chan_t    = ace_snoop_responder_pkg::ac_chan_t,
    parameter type cr_chan_t    = ace_snoop_responder_pkg::cr_chan_t,
    parameter type cd_chan_t    = ace_snoop_responder_pkg::cd_chan_t,
    parameter type snoop_req_t  = ace_snoop_responder_pkg::snoop_req_t,
    parameter type snoop_resp_t = ace_snoop_responder_pkg::snoop_resp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  snoop_req_t                   snoop_req_i,
    output snoop_resp_t                  snoop_resp_o,
    output logic                         lookup_valid_o,
    output logic [AddrWidth-1:0]         lookup_addr_o,
    input  logic                         lookup_ready_i,
    input  logic                         lookup_rsp_valid_i,
    input  logic                         lookup_hit_i,
    input  logic                         lookup_dirty_i,
    input  logic                         lookup_shared_i,
    input  logic [CdBeats*DataWidth-1:0] lookup_line_i,
    output logic                         upd_valid_o,
    output logic                         upd_invalidate_o,
    output logic                         upd_clean_o
);
    import ace_snoop_responder_pkg::*;

    localparam int unsigned BeatW = (CdBeats > 1) ? $clog2(CdBeats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(CdBeats - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT_RSP,
        RESP,
        DATA
    } state_e;

    state_e                       state_q, state_d;
    ac_chan_t                     ac_q, ac_d;
    logic                         hit_q, hit_d;
    cr_chan_t                     cr_q, cr_d;
    logic [CdBeats*DataWidth-1:0] line_q, line_d;
    logic [BeatW-1:0]             beat_q, beat_d;
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
    logic                         cr_done_q, cr_done_d;
    logic                         cd_done_q, cd_done_d;
`endif

    cr_chan_t cr_calc;
    cd_chan_t cd_beat;
    logic     ac_ready, cr_valid, cd_valid;
    logic     cr_hs, cd_hs, last_beat;
    logic     unused_prot;

    assign last_beat     = (beat_q == LastBeat);
    assign lookup_addr_o = ac_q.addr;
    assign unused_prot   = ^ac_q.prot;

    // CR derived from the latched snoop type and the live lookup result.
    always_comb begin
        logic dt, is;
        cr_calc = '0;
        dt      = 1'b0;
        is      = 1'b1;
        unique case (ac_q.snoop)
            SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
                dt = 1'b1;
                is = 1'b1;
            end
            SNP_READ_UNIQUE: begin
                dt = 1'b1;
                is = 1'b0;
            end
            SNP_CLEAN_SHARED: begin
                dt = lookup_dirty_i;
                is = 1'b1;
            end
            SNP_CLEAN_INVALID: begin
                dt = lookup_dirty_i;
                is = 1'b0;
            end
            SNP_MAKE_INVALID: begin
                dt = 1'b0;
                is = 1'b0;
            end
            default: begin
                dt = 1'b0;
                is = 1'b1;
            end
        endcase
        if (lookup_hit_i) begin
            cr_calc.data_transfer = dt;
            cr_calc.pass_dirty    = lookup_dirty_i && dt && (ac_q.snoop != SNP_READ_ONCE);
            cr_calc.is_shared     = is;
            cr_calc.was_unique    = !lookup_shared_i;
        end
    end

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        hit_d     = hit_q;
        cr_d      = cr_q;
        line_d    = line_q;
        beat_d    = beat_q;
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
        cr_done_d = cr_done_q;
        cd_done_d = cd_done_q;
`endif
        ac_ready       = 1'b0;
        cr_valid       = 1'b0;
        cd_valid       = 1'b0;
        cr_hs          = 1'b0;
        cd_hs          = 1'b0;
        lookup_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                ac_ready = 1'b1;
                if (snoop_req_i.ac_valid) begin
                    ac_d    = snoop_req_i.ac;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lookup_valid_o = 1'b1;
                if (lookup_ready_i) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (lookup_rsp_valid_i) begin
                    hit_d   = lookup_hit_i;
                    cr_d    = cr_calc;
                    line_d  = lookup_line_i;
                    beat_d  = '0;
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
                    cr_done_d = 1'b0;
                    cd_done_d = 1'b0;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
                // CR and CD run independently; leave once both sides are finished.
                cr_valid = !cr_done_q;
                cd_valid = cr_q.data_transfer && !cd_done_q;
                cr_hs    = cr_valid && snoop_req_i.cr_ready;
                cd_hs    = cd_valid && snoop_req_i.cd_ready;
                if (cr_hs) cr_done_d = 1'b1;
                if (cd_hs && last_beat) cd_done_d = 1'b1;
                if ((cr_done_q || cr_hs) &&
                    (!cr_q.data_transfer || cd_done_q || (cd_hs && last_beat))) begin
                    state_d = IDLE;
                end
`else
                cr_valid = 1'b1;
                cr_hs    = snoop_req_i.cr_ready;
                if (cr_hs) state_d = cr_q.data_transfer ? DATA : IDLE;
`endif
            end
            DATA: begin
                cd_valid = 1'b1;
                cd_hs    = snoop_req_i.cd_ready;
                if (cd_hs && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cd_hs) beat_d = last_beat ? '0 : beat_q + BeatW'(1);
    end

    always_comb begin
        cd_beat = '0;
        if (cd_valid) begin
            cd_beat.data = line_q[int'(beat_q)*DataWidth +: DataWidth];
            cd_beat.last = last_beat;
        end
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = ac_ready;
        snoop_resp_o.cr_valid = cr_valid;
        snoop_resp_o.cr_resp  = cr_q;
        snoop_resp_o.cd_valid = cd_valid;
        snoop_resp_o.cd       = cd_beat;

        upd_valid_o      = cr_hs && hit_q;
        upd_invalidate_o = upd_valid_o && !cr_q.is_shared;
        upd_clean_o      = upd_valid_o && cr_q.pass_dirty && cr_q.is_shared;
    end

    // NOTE: the line buffer is an ordinary register, so it is cleared on reset like the rest.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ac_q      <= '0;
            hit_q     <= 1'b0;
            cr_q      <= '0;
            line_q    <= '0;
            beat_q    <= '0;
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
            cr_done_q <= 1'b0;
            cd_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ac_q      <= ac_d;
            hit_q     <= hit_d;
            cr_q      <= cr_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
            cr_done_q <= cr_done_d;
            cd_done_q <= cd_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: vector table of snoop transactions plus
// hand-written reset/overlap sequences; CD beats are checked against a scoreboard queue.
module tb_ace_snoop_responder;
    import ace_snoop_responder_pkg::*;

    localparam int NB = 8;
    localparam int DW = 64;

    logic               clk = 1'b0;
    logic               rst_ni;
    snoop_req_t         req;
    snoop_resp_t        rsp;
    logic               lookup_valid;
    logic [63:0]        lookup_addr;
    logic               lookup_ready;
    logic               rsp_valid;
    logic               hit, dirty, shared;
    logic [NB*DW-1:0]   line;
    logic               upd_valid, upd_inv, upd_clean;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ac_cyc   = 0;

    typedef struct {
        logic [3:0]  snoop;
        logic [63:0] addr;
        logic        hit;
        logic        dirty;
        logic        shared;
        logic [4:0]  exp_cr;   // {was_unique, is_shared, pass_dirty, error, data_transfer}
        logic        exp_upd;
        logic        exp_inv;
        logic        exp_clean;
        int          lwait;
        int          cwait;
        logic        toggle;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    vec_t  vecs[11];

    ace_snoop_responder dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .snoop_req_i        (req),
        .snoop_resp_o       (rsp),
        .lookup_valid_o     (lookup_valid),
        .lookup_addr_o      (lookup_addr),
        .lookup_ready_i     (lookup_ready),
        .lookup_rsp_valid_i (rsp_valid),
        .lookup_hit_i       (hit),
        .lookup_dirty_i     (dirty),
        .lookup_shared_i    (shared),
        .lookup_line_i      (line),
        .upd_valid_o        (upd_valid),
        .upd_invalidate_o   (upd_inv),
        .upd_clean_o        (upd_clean)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or scoreboard empty", name);
    endtask

    function automatic logic [NB*DW-1:0] mk_line(input logic [63:0] base);
        logic [NB*DW-1:0] l;
        l = '0;
        for (int k = 0; k < NB; k++) l[k*DW +: DW] = base + 64'(k);
        return l;
    endfunction

    function automatic vec_t mkv(input logic [3:0] snoop, input logic [63:0] addr,
                                 input logic h, input logic d, input logic s,
                                 input logic [4:0] cr, input logic u, input logic inv,
                                 input logic cln, input int lw, input int cw, input logic tg);
        vec_t v;
        v.snoop = snoop; v.addr = addr; v.hit = h; v.dirty = d; v.shared = s;
        v.exp_cr = cr; v.exp_upd = u; v.exp_inv = inv; v.exp_clean = cln;
        v.lwait = lw; v.cwait = cw; v.toggle = tg;
        return v;
    endfunction

    task automatic do_snoop(input vec_t v, input logic [NB*DW-1:0] ln, input int abort_after);
        int    nbeats;
        int    t;
        logic  tog;
        beat_t b;
        // AC handshake
        @(negedge clk);
        req.ac_valid = 1'b1;
        req.ac.addr  = v.addr;
        req.ac.snoop = v.snoop;
        req.ac.prot  = 3'b010;
        #1 check("ac_ready_idle", rsp.ac_ready, 1'b1);
        ac_cyc = cyc;
        @(negedge clk);
        req.ac_valid = 1'b0;
        req.ac.addr  = ~v.addr;
        req.ac.snoop = 4'hF;
        // lookup request, possibly back-pressured
        for (int i = 0; i <= v.lwait; i++) begin
            lookup_ready = (i == v.lwait);
            #1;
            check("lookup_valid", lookup_valid, 1'b1);
            check("lookup_addr", lookup_addr, v.addr);
            check("ac_ready_busy", rsp.ac_ready, 1'b0);
            @(negedge clk);
        end
        lookup_ready = 1'b0;
        rsp_valid = 1'b1;
        hit = v.hit; dirty = v.dirty; shared = v.shared;
        line = ln;
        if (v.exp_cr[0])
            for (int k = 0; k < NB; k++) sb.push_back('{data: ln[k*DW +: DW], last: (k == NB-1)});
        #1;
        check("lookup_valid_wait", lookup_valid, 1'b0);
        check("cr_valid_wait", rsp.cr_valid, 1'b0);
        @(negedge clk);
        rsp_valid = 1'b0;
        hit = 1'b0; dirty = 1'b0; shared = 1'b0;
        line = ~ln;
        // CR phase
        for (int i = 0; i <= v.cwait; i++) begin
            req.cr_ready = (i == v.cwait);
            req.cd_ready = 1'b0;
            #1;
            check("cr_valid", rsp.cr_valid, 1'b1);
            check("cr_resp", rsp.cr_resp, v.exp_cr);
            check("ac_ready_cr", rsp.ac_ready, 1'b0);
`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
            check("cd_valid_cr", rsp.cd_valid, v.exp_cr[0]);
`else
            check("cd_valid_cr", rsp.cd_valid, 1'b0);
`endif
            if (i == v.cwait) begin
                check("upd_valid", upd_valid, v.exp_upd);
                check("upd_invalidate", upd_inv, v.exp_inv);
                check("upd_clean", upd_clean, v.exp_clean);
            end else begin
                check("upd_valid_stall", upd_valid, 1'b0);
            end
            @(negedge clk);
        end
        req.cr_ready = 1'b0;
        // CD phase
        if (v.exp_cr[0]) begin
            nbeats = 0;
            t      = 0;
            tog    = 1'b0;
            while (nbeats < NB && t < 200) begin
                req.cd_ready = v.toggle ? tog : 1'b1;
                tog = ~tog;
                #1;
                check("cd_valid", rsp.cd_valid, 1'b1);
                check("ac_ready_data", rsp.ac_ready, 1'b0);
                if (sb.size() == 0) begin
                    fail_now("cd_scoreboard");
                    break;
                end
                b = sb[0];
                check("cd_data", rsp.cd.data, b.data);
                check("cd_last", rsp.cd.last, b.last);
                if (req.cd_ready) begin
                    void'(sb.pop_front());
                    nbeats++;
                end
                @(negedge clk);
                t++;
                if (abort_after > 0 && nbeats == abort_after) begin
                    req.cd_ready = 1'b0;
                    return;
                end
            end
            req.cd_ready = 1'b0;
            if (t >= 200) fail_now("cd_timeout");
            check("beat_count", nbeats, NB);
        end
        #1;
        check("ac_ready_back", rsp.ac_ready, 1'b1);
        check("cd_valid_idle", rsp.cd_valid, 1'b0);
        check("cr_valid_idle", rsp.cr_valid, 1'b0);
        if (!v.exp_cr[0] && v.lwait == 0 && v.cwait == 0)
            check("ac_to_idle_cycles", cyc - ac_cyc, 4);
    endtask

    initial begin
        vec_t v;
        // snoop, addr, hit, dirty, shared, cr{WU,IS,PD,ERR,DT}, upd, inv, clean, lwait, cwait, toggle
        vecs[0]  = mkv(SNP_READ_SHARED,   64'h1000, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(SNP_READ_UNIQUE,   64'h2040, 1, 1, 0, 5'b10101, 1, 1, 0, 0, 0, 0);
        vecs[2]  = mkv(SNP_CLEAN_SHARED,  64'h3000, 1, 0, 1, 5'b01000, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(SNP_CLEAN_SHARED,  64'h3000, 1, 1, 0, 5'b11101, 1, 0, 1, 0, 0, 0);
        vecs[4]  = mkv(SNP_READ_ONCE,     64'h4000, 1, 1, 1, 5'b01001, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mkv(SNP_READ_SHARED,   64'h5080, 1, 0, 0, 5'b11001, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mkv(SNP_CLEAN_INVALID, 64'h6000, 1, 1, 1, 5'b00101, 1, 1, 0, 0, 0, 0);
        vecs[7]  = mkv(SNP_READ_NSD,      64'h7040, 1, 1, 0, 5'b11101, 1, 0, 1, 0, 0, 0);
        vecs[8]  = mkv(SNP_MAKE_INVALID,  64'h8000, 1, 1, 0, 5'b10000, 1, 1, 0, 0, 0, 0);
        vecs[9]  = mkv(SNP_READ_CLEAN,    64'h9000, 0, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
        vecs[10] = mkv(SNP_READ_UNIQUE,   64'hA0C0, 1, 0, 1, 5'b00001, 1, 1, 0, 5, 3, 1);

        rst_ni = 1'b0;
        req = '0;
        lookup_ready = 1'b0;
        rsp_valid = 1'b0;
        hit = 1'b0; dirty = 1'b0; shared = 1'b0;
        line = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ac_ready", rsp.ac_ready, 1'b1);
        check("rst_cr_valid", rsp.cr_valid, 1'b0);
        check("rst_cd_valid", rsp.cd_valid, 1'b0);
        check("rst_cr_resp", rsp.cr_resp, 5'b0);
        check("rst_cd", rsp.cd, '0);
        check("rst_lookup_valid", lookup_valid, 1'b0);
        check("rst_upd", {upd_valid, upd_inv, upd_clean}, 3'b000);
        @(negedge clk);
        rst_ni = 1'b1;

        // stray responses / readies in IDLE are ignored
        @(negedge clk);
        rsp_valid = 1'b1; hit = 1'b1; dirty = 1'b1;
        req.cr_ready = 1'b1; req.cd_ready = 1'b1;
        #1 check("idle_no_upd", upd_valid, 1'b0);
        @(negedge clk);
        rsp_valid = 1'b0; hit = 1'b0; dirty = 1'b0;
        req.cr_ready = 1'b0; req.cd_ready = 1'b0;
        #1;
        check("idle_ignore_ac_ready", rsp.ac_ready, 1'b1);
        check("idle_ignore_cr_valid", rsp.cr_valid, 1'b0);
        check("idle_ignore_lookup", lookup_valid, 1'b0);

        for (int i = 0; i < 11; i++)
            do_snoop(vecs[i], mk_line((i == 1) ? 64'h0 : 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h100), 0);

        // reset in the middle of the data phase, after beat 3
        do_snoop(vecs[1], mk_line(64'hBEEF_0000_0000_0000), 4);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        sb.delete();
        #1;
        check("midrst_cd_valid", rsp.cd_valid, 1'b0);
        check("midrst_ac_ready", rsp.ac_ready, 1'b1);
        check("midrst_cr_valid", rsp.cr_valid, 1'b0);
        check("midrst_cr_resp", rsp.cr_resp, 5'b0);
        v = mkv(SNP_MAKE_INVALID, 64'hC000, 1, 0, 1, 5'b00000, 1, 1, 0, 0, 0, 0);
        do_snoop(v, mk_line(64'h1234_0000_0000_0000), 0);

`ifdef ACE_SNOOP_RESPONDER_CR_CD_OVERLAP_EN
        // CD completes entirely while CR is held off, then CR completes
        begin
            logic [NB*DW-1:0] ln;
            beat_t b;
            ln = mk_line(64'hCAFE_0000_0000_0000);
            @(negedge clk);
            req.ac_valid = 1'b1; req.ac.addr = 64'hD000; req.ac.snoop = SNP_READ_CLEAN;
            @(negedge clk);
            req.ac_valid = 1'b0; lookup_ready = 1'b1;
            @(negedge clk);
            lookup_ready = 1'b0;
            rsp_valid = 1'b1; hit = 1'b1; dirty = 1'b0; shared = 1'b1; line = ln;
            for (int k = 0; k < NB; k++) sb.push_back('{data: ln[k*DW +: DW], last: (k == NB-1)});
            @(negedge clk);
            rsp_valid = 1'b0; hit = 1'b0; shared = 1'b0;
            for (int i = 0; i < 10; i++) begin
                req.cr_ready = 1'b0;
                req.cd_ready = 1'b1;
                #1;
                check("ovl_cr_valid", rsp.cr_valid, 1'b1);
                check("ovl_cr_resp", rsp.cr_resp, 5'b01001);
                if (i < NB) begin
                    check("ovl_cd_valid", rsp.cd_valid, 1'b1);
                    b = sb.pop_front();
                    check("ovl_cd_data", rsp.cd.data, b.data);
                    check("ovl_cd_last", rsp.cd.last, b.last);
                end else begin
                    check("ovl_cd_done", rsp.cd_valid, 1'b0);
                end
                @(negedge clk);
            end
            req.cd_ready = 1'b0;
            req.cr_ready = 1'b1;
            #1;
            check("ovl_upd_valid", upd_valid, 1'b1);
            check("ovl_upd_flags", {upd_inv, upd_clean}, 2'b00);
            @(negedge clk);
            req.cr_ready = 1'b0;
            #1 check("ovl_ac_ready", rsp.ac_ready, 1'b1);
        end
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
